// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one full-adder cell over WIDTH cycles, LSB first,
// and owns the operand shifters, carry flop, bit counter and result registers.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;

  always_comb begin
    fa_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          res_d   = '0;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        // On the MSB cycle carry_q is the carry into the MSB, needed for Ovf.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: vector table plus handshake corner cases.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Cin = 1'b0;
  logic       busy, done, Cout, Ovf;
  logic [7:0] Sum;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // done and busy must never be high together
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b at %0t", busy, done, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Call just after a posedge (or while idle). poke>0 injects a mid-RUN start/operand change.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input int poke, output int lat, output int busy_cnt);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == poke) begin
        start = 1'b1; A = 8'hAA; B = 8'h11; Cin = 1'b1;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bc, gap;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {24'd0, Sum}, 32'd0);
    chk("reset_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, lat, bc);
      chk($sformatf("vec%0d_latency", i), lat, 32'd8);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd8);
      chk($sformatf("vec%0d_sum", i), {24'd0, Sum}, {24'd0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, Cout}, {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_ovf", i), {31'd0, Ovf}, {31'd0, vecs[i].ovf});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {30'd0, done, busy}, 32'd0);
      chk($sformatf("vec%0d_sum_hold", i), {24'd0, Sum}, {24'd0, vecs[i].sum});
    end

    // start and operand changes mid-RUN are ignored
    do_op(8'h05, 8'h03, 1'b0, 3, lat, bc);
    chk("busyprot_latency", lat, 32'd8);
    chk("busyprot_sum", {24'd0, Sum}, 32'h08);
    chk("busyprot_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
    bc = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) bc++;
    end
    chk("busyprot_no_retrigger", bc, 32'd0);

    // back-to-back: start held during DONE launches the next op
    do_op(8'h05, 8'h03, 1'b0, 0, lat, bc);
    chk("b2b_first_latency", lat, 32'd8);
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_after_done", {30'd0, busy, done}, 32'd2);
    gap = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin gap = k; break; end
    end
    chk("b2b_gap", gap, 32'd9);
    chk("b2b_sum", {24'd0, Sum}, 32'h30);
    chk("b2b_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
    @(posedge clk); #1;

    // sum nonzero beforehand so the reset clear is visible
    do_op(8'h80, 8'h80, 1'b0, 0, lat, bc);
    A = 8'h05; B = 8'h03; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_mid_sum", {24'd0, Sum}, 32'd0);
    chk("rst_mid_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bc = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) bc++;
    end
    chk("rst_no_done_after", bc, 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 0, lat, bc);
    chk("rst_fresh_latency", lat, 32'd8);
    chk("rst_fresh_sum", {24'd0, Sum}, 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences a single 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requesting master (start/done handshake) and the full-adder datapath. It owns the operand shift registers, the carry flip-flop, the bit counter and the result register. It trades WIDTH cycles of latency for one adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on rising clk edges in IDLE or DONE only.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- Sum  output  WIDTH  registered result; holds its value until the next completion.
- Cout  output  1  registered carry-out of the MSB.
- Ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- States:
  - IDLE: waiting for a request.
  - RUN: one bit position added per cycle.
  - DONE: one-cycle result strobe.
- Reset (rst_n low, any time, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - shift registers, carry flip-flop and counter cleared.
- IDLE or DONE with start=1:
  - latch A and B into the shift registers; carry flip-flop = Cin; counter = 0.
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - full-adder cell inputs: a_sh[0], b_sh[0], carry flip-flop.
  - cell sum bit shifts into the result shift register at its MSB end; a_sh and b_sh shift right.
  - carry flip-flop takes the cell carry.
  - counter increments.
  - when counter==WIDTH-1 on this edge, the carry feeding the cell is the carry into the MSB; it is kept for Ovf.
- Completion (edge where counter==WIDTH-1), all on that same edge:
  - Sum = final shifted result.
  - Cout = cell carry.
  - Ovf = carry-into-MSB XOR cell carry.
  - state goes to DONE.
- start while in RUN is ignored. The operation is not restarted and no error flag is raised.
- Operand changes on A, B or Cin after the accepting edge have no effect.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). Ovf is the two's-complement overflow of A + B + Cin.
- Reset during RUN aborts the operation: no done pulse, Sum is cleared to 0.

## Timing
- Accepting edge E0 (start=1 in IDLE or DONE).
- busy is high from after E0 until after edge E(WIDTH). That is exactly WIDTH cycles.
- done is high for exactly one cycle, after edge E(WIDTH).
- Sum, Cout and Ovf update on edge E(WIDTH). They are stable during the done cycle and after it.
- Latency from start to done is WIDTH cycles.
- Back-to-back operation: start held high during the DONE cycle launches the next operation. Throughput is then one result per WIDTH+1 cycles.
- A start held high continuously re-triggers on every DONE cycle.
- done and busy are never high together. busy is never high in IDLE.

## Test plan
- Basic add, WIDTH=8: A=8'h0F, B=8'h01, Cin=0, single start pulse -> done exactly 8 cycles later; Sum=8'h10, Cout=0, Ovf=0; busy high for 8 cycles.
- Carry and wrap: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1, Ovf=0. Then A=8'h00, B=8'h00, Cin=1 -> Sum=8'h01, Cout=0.
- Signed overflow: A=8'h7F, B=8'h01 -> Sum=8'h80, Cout=0, Ovf=1. A=8'h80, B=8'h80 -> Sum=8'h00, Cout=1, Ovf=1.
- Busy protection: start 8'h05+8'h03, then pulse start with A=8'hAA mid-RUN and change A/B mid-RUN -> single done, Sum=8'h08, no re-trigger.
- Back-to-back: start held high through the DONE cycle with new operands 8'h10+8'h20 -> second done 9 cycles after the first, Sum=8'h30.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN -> busy, done, Sum, Cout and Ovf all 0 immediately. After release, no done until the next start; a fresh 8'h01+8'h01 gives Sum=8'h02.
- Exhaustive check, optional sweep: all A, B in 0..255 with Cin in {0,1} against a reference model.
